// File: rtl/qsfp_i2c_axi_regs_if.sv
// AXI4-Lite bus bundle between the host/traffic generator and the QSFP I2C
// register file.
interface qsfp_i2c_axi_regs_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/qsfp_i2c_axi_regs.sv
// AXI4-Lite register file fronting the QSFP I2C engine: latches command fields,
// pulses i2c_start, and captures completion status and the read byte.
module qsfp_i2c_axi_regs #(
   parameter int          AXI_ADDR_WIDTH = 32,
   parameter int          AXI_DATA_WIDTH = 32,
   parameter logic [31:0] VERSION        = 32'h0001_0000
) (
   input  logic                s_axi_aclk,
   input  logic                s_axi_areset,
   qsfp_i2c_axi_regs_if.slave  s_axi,
   output logic                i2c_start,
   output logic                i2c_rw,
   output logic [7:0]          i2c_dev_id,
   output logic [15:0]         i2c_reg_addr,
   output logic [7:0]          i2c_wdata,
   input  logic                i2c_done,
   input  logic                i2c_nack,
   input  logic [7:0]          i2c_rdata
);
   localparam logic [5:0] OFF_CTRL    = 6'h00;
   localparam logic [5:0] OFF_ADDR    = 6'h04;
   localparam logic [5:0] OFF_WDATA   = 6'h08;
   localparam logic [5:0] OFF_RDATA   = 6'h0C;
   localparam logic [5:0] OFF_VERSION = 6'h20;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t                  w_state;
   logic                      awready_q, wready_q, bvalid_q;
   logic [1:0]                bresp_q;
   logic                      aw_held, w_held;
   logic [5:0]                aw_addr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [3:0]                wstrb_q;

   r_state_t                  r_state;
   logic                      arready_q, rvalid_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q;
   logic [1:0]                rresp_q;

   logic                      op_q, done_q, nack_q, busy_q, start_q;
   logic [7:0]                dev_id_q, wbyte_q, rbyte_q;
   logic [15:0]               reg_addr_q;

   function automatic logic offset_valid(input logic [5:0] off);
      return off inside {OFF_CTRL, OFF_ADDR, OFF_WDATA, OFF_RDATA, OFF_VERSION};
   endfunction

   // A write completes from whichever mix of latched and same-cycle AW/W beats exists.
   logic                      aw_fire, w_fire, ar_fire, wr_en;
   logic [5:0]                wr_addr;
   logic [AXI_DATA_WIDTH-1:0] wr_data;
   logic [3:0]                wr_strb;
   logic                      wr_ctrl, start_req, start_ok;
   logic [1:0]                wr_resp;

   assign aw_fire   = s_axi.awvalid & awready_q;
   assign w_fire    = s_axi.wvalid & wready_q;
   assign ar_fire   = s_axi.arvalid & arready_q;
   assign wr_addr   = aw_held ? aw_addr_q : s_axi.awaddr[5:0];
   assign wr_data   = w_held ? wdata_q : s_axi.wdata;
   assign wr_strb   = w_held ? wstrb_q : s_axi.wstrb;
   assign wr_en     = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
   assign wr_ctrl   = wr_en & (wr_addr == OFF_CTRL);
   assign start_req = wr_ctrl & wr_strb[0];
   assign start_ok  = start_req & ~busy_q;
   assign wr_resp   = !offset_valid(wr_addr) ? RESP_DECERR :
                      (start_req & busy_q)    ? RESP_SLVERR : RESP_OKAY;

   logic unused_bits;
   assign unused_bits = ^{s_axi.awaddr, s_axi.araddr, wr_data, wr_strb};

   // NOTE: state registers use non-blocking (<=) so every block sees pre-edge values.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (wr_en) begin
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_resp;
                  w_state   <= W_RESP;
               end else begin
                  if (aw_fire) begin
                     aw_held   <= 1'b1;
                     aw_addr_q <= s_axi.awaddr[5:0];
                  end
                  if (w_fire) begin
                     w_held  <= 1'b1;
                     wdata_q <= s_axi.wdata;
                     wstrb_q <= s_axi.wstrb;
                  end
                  awready_q <= ~(aw_held | aw_fire);
                  wready_q  <= ~(w_held | w_fire);
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
         endcase
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   logic [AXI_DATA_WIDTH-1:0] rd_word;
   always_comb begin
      rd_word = '0;
      case (s_axi.araddr[5:0])
         OFF_CTRL:    rd_word = {op_q, done_q, nack_q, busy_q, 20'h0, dev_id_q};
         OFF_ADDR:    rd_word = {16'h0, reg_addr_q};
         OFF_WDATA:   rd_word = {24'h0, wbyte_q};
         OFF_RDATA:   rd_word = {24'h0, rbyte_q};
         OFF_VERSION: rd_word = VERSION;
         default:     rd_word = '0;
      endcase
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  rdata_q   <= rd_word;
                  rresp_q   <= offset_valid(s_axi.araddr[5:0]) ? RESP_OKAY : RESP_DECERR;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  r_state   <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
         endcase
      end
   end

   // Start and done are mutually exclusive: start needs BUSY low, done needs it high.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         op_q       <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         dev_id_q   <= '0;
         reg_addr_q <= '0;
         wbyte_q    <= '0;
         rbyte_q    <= '0;
      end else begin
         start_q <= start_ok;
         if (start_ok) begin
            if (wr_strb[3]) op_q <= wr_data[31];
            dev_id_q <= wr_data[7:0];
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
         end else if (wr_ctrl && !wr_strb[0] && wr_strb[3]) begin
            op_q <= wr_data[31];
         end
         if (i2c_done && busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            nack_q <= i2c_nack;
            if (op_q) rbyte_q <= i2c_rdata;
         end
         if (wr_en && wr_addr == OFF_ADDR) begin
            if (wr_strb[0]) reg_addr_q[7:0]  <= wr_data[7:0];
            if (wr_strb[1]) reg_addr_q[15:8] <= wr_data[15:8];
         end
         if (wr_en && wr_addr == OFF_WDATA && wr_strb[0]) wbyte_q <= wr_data[7:0];
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;

   assign i2c_start    = start_q;
   assign i2c_rw       = op_q;
   assign i2c_dev_id   = dev_id_q;
   assign i2c_reg_addr = reg_addr_q;
   assign i2c_wdata    = wbyte_q;
endmodule

// File: tb/tb_qsfp_i2c_axi_regs.sv
// Directed plus randomized bench for qsfp_i2c_axi_regs against a register-map
// level model of the block.
module tb_qsfp_i2c_axi_regs;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qsfp_i2c_axi_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

   logic        i2c_start, i2c_rw;
   logic [7:0]  i2c_dev_id, i2c_wdata;
   logic [15:0] i2c_reg_addr;
   logic        i2c_done  = 1'b0;
   logic        i2c_nack  = 1'b0;
   logic [7:0]  i2c_rdata = 8'h00;

   qsfp_i2c_axi_regs dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst),
      .s_axi        (s_axi),
      .i2c_start    (i2c_start),
      .i2c_rw       (i2c_rw),
      .i2c_dev_id   (i2c_dev_id),
      .i2c_reg_addr (i2c_reg_addr),
      .i2c_wdata    (i2c_wdata),
      .i2c_done     (i2c_done),
      .i2c_nack     (i2c_nack),
      .i2c_rdata    (i2c_rdata)
   );

   int tests  = 0;
   int failed = 0;

   // Behavioural register-map model.
   bit          m_op, m_done, m_nack, m_busy;
   logic [7:0]  m_dev, m_wbyte, m_rbyte;
   logic [15:0] m_addr;
   int          m_starts = 0;
   int          start_cnt = 0;

   always @(negedge clk) if (i2c_start === 1'b1) start_cnt++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_op = 0; m_done = 0; m_nack = 0; m_busy = 0;
      m_dev = 0; m_wbyte = 0; m_rbyte = 0; m_addr = 0;
   endtask

   task automatic model_read(input logic [5:0] off, output logic [31:0] d, output logic [1:0] resp);
      resp = 2'b00;
      d    = 32'h0;
      case (off)
         6'h00:   d = {m_op, m_done, m_nack, m_busy, 20'h0, m_dev};
         6'h04:   d = {16'h0, m_addr};
         6'h08:   d = {24'h0, m_wbyte};
         6'h0C:   d = {24'h0, m_rbyte};
         6'h20:   d = 32'h0001_0000;
         default: resp = 2'b11;
      endcase
   endtask

   task automatic model_write(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp, output bit start);
      resp  = 2'b00;
      start = 0;
      case (off)
         6'h00: begin
            if (s[0]) begin
               if (m_busy) resp = 2'b10;
               else begin
                  if (s[3]) m_op = d[31];
                  m_dev = d[7:0]; m_busy = 1; m_done = 0; m_nack = 0;
                  start = 1; m_starts++;
               end
            end else if (s[3]) m_op = d[31];
         end
         6'h04: begin
            if (s[0]) m_addr[7:0]  = d[7:0];
            if (s[1]) m_addr[15:8] = d[15:8];
         end
         6'h08: if (s[0]) m_wbyte = d[7:0];
         6'h0C, 6'h20: ;
         default: resp = 2'b11;
      endcase
   endtask

   task automatic model_done(input bit nack, input logic [7:0] rd);
      if (m_busy) begin
         m_busy = 0; m_done = 1; m_nack = nack;
         if (m_op) m_rbyte = rd;
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int b_delay, input bit with_done,
                            input bit dn_nack, input logic [7:0] dn_rdata, input bit hold_resp);
      logic [1:0] exp_resp;
      bit exp_start, aw_ok, w_ok, aw_go, w_go;
      int n, guard;
      guard = 0;
      while (!(s_axi.awready && s_axi.wready) && guard < 20) begin tick(); guard++; end
      model_write(addr[5:0], data, strb, exp_resp, exp_start);
      if (with_done) model_done(dn_nack, dn_rdata);
      s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
      s_axi.wvalid = 1'b1;
      if (with_done) begin i2c_done = 1'b1; i2c_nack = dn_nack; i2c_rdata = dn_rdata; end
      aw_ok = 0; w_ok = 0; n = 0;
      while (!(aw_ok && w_ok) && n < 50) begin
         if (n == aw_delay && !aw_ok) s_axi.awvalid = 1'b1;
         aw_go = s_axi.awvalid && s_axi.awready;
         w_go  = s_axi.wvalid && s_axi.wready;
         tick(); n++;
         i2c_done = 1'b0;
         if (aw_go) begin aw_ok = 1; s_axi.awvalid = 1'b0; end
         if (w_go)  begin w_ok = 1;  s_axi.wvalid  = 1'b0; end
      end
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      check("write_handshakes", {30'h0, aw_ok, w_ok}, 32'h3);
      check("bvalid_latency", s_axi.bvalid, 1);
      check("bresp", s_axi.bresp, exp_resp);
      check("start_pulse", i2c_start, exp_start);
      if (exp_start) begin
         check("start_rw", i2c_rw, m_op);
         check("start_dev_id", i2c_dev_id, m_dev);
         check("start_reg_addr", i2c_reg_addr, m_addr);
         check("start_wdata", i2c_wdata, m_wbyte);
      end
      if (!hold_resp) begin
         for (int i = 0; i < b_delay; i++) begin
            tick();
            check("bvalid_hold", s_axi.bvalid, 1);
            check("bresp_hold", s_axi.bresp, exp_resp);
         end
         s_axi.bready = 1'b1;
         tick();
         s_axi.bready = 1'b0;
         check("bvalid_drop", s_axi.bvalid, 0);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_delay, input bit with_done,
                           input bit dn_nack, input logic [7:0] dn_rdata);
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int guard;
      guard = 0;
      while (!s_axi.arready && guard < 20) begin tick(); guard++; end
      check("arready_idle", s_axi.arready, 1);
      model_read(addr[5:0], exp_data, exp_resp);
      if (with_done) begin
         model_done(dn_nack, dn_rdata);
         i2c_done = 1'b1; i2c_nack = dn_nack; i2c_rdata = dn_rdata;
      end
      s_axi.araddr = addr; s_axi.arvalid = 1'b1;
      tick();
      s_axi.arvalid = 1'b0; i2c_done = 1'b0;
      check("rvalid_latency", s_axi.rvalid, 1);
      check($sformatf("rdata@%02h", addr[7:0]), s_axi.rdata, exp_data);
      check($sformatf("rresp@%02h", addr[7:0]), s_axi.rresp, exp_resp);
      for (int i = 0; i < r_delay; i++) begin
         tick();
         check("rvalid_hold", s_axi.rvalid, 1);
         check("rdata_hold", s_axi.rdata, exp_data);
      end
      s_axi.rready = 1'b1;
      tick();
      s_axi.rready = 1'b0;
      check("rvalid_drop", s_axi.rvalid, 0);
   endtask

   task automatic drive_done(input bit nack, input logic [7:0] rd);
      model_done(nack, rd);
      i2c_done = 1'b1; i2c_nack = nack; i2c_rdata = rd;
      tick();
      i2c_done = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      axi_write(addr, data, 4'hF, 0, 0, 0, 0, 8'h00, 0);
   endtask

   task automatic rd(input logic [31:0] addr);
      axi_read(addr, 0, 0, 0, 8'h00);
   endtask

   initial begin
      s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 0; s_axi.bready = 0; s_axi.araddr = '0; s_axi.arvalid = 0;
      s_axi.rready = 0;
      model_reset();

      // Reset state
      repeat (3) tick();
      check("rst_awready", s_axi.awready, 0);
      check("rst_wready", s_axi.wready, 0);
      check("rst_arready", s_axi.arready, 0);
      check("rst_bvalid", s_axi.bvalid, 0);
      check("rst_rvalid", s_axi.rvalid, 0);
      check("rst_start", i2c_start, 0);
      rst = 1'b0;
      tick();

      // 1. Reset values and version
      rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C); rd(32'h20);

      // 2. Write-type operation
      wr(32'h04, 32'h0000_0001);
      wr(32'h08, 32'h0000_00AA);
      wr(32'h00, 32'h0000_0042);
      check("start_count_1", start_cnt, 1);
      rd(32'h00);

      // 3. Completion of a write
      drive_done(0, 8'h77);
      rd(32'h00);
      rd(32'h0C);

      // 4. Read-type operation
      wr(32'h00, 32'h8000_0042);
      drive_done(0, 8'h5C);
      rd(32'h0C);
      rd(32'h00);

      // 5. Rejected start while busy, decode errors, coincident events
      wr(32'h00, 32'h8000_0011);
      wr(32'h00, 32'h0000_0033);
      check("start_count_busy", start_cnt, m_starts);
      rd(32'h14);
      wr(32'h14, 32'hFFFF_FFFF);
      axi_write(32'h00, 32'h0000_0055, 4'h8, 0, 0, 0, 0, 8'h00, 0);
      axi_write(32'h00, 32'h8000_0066, 4'hF, 0, 0, 1, 1, 8'hE1, 0);
      rd(32'h00); rd(32'h0C);
      wr(32'h00, 32'h8000_0017);
      axi_read(32'h00, 0, 1, 0, 8'h3C);
      rd(32'h00); rd(32'h0C);

      // 6. W ahead of AW, stalled responses, reset mid-operation
      axi_write(32'h08, 32'h0000_00C3, 4'h1, 3, 4, 0, 0, 8'h00, 0);
      axi_read(32'h08, 4, 0, 0, 8'h00);
      wr(32'h00, 32'h0000_0050);
      axi_write(32'h04, 32'h0000_BEEF, 4'h3, 0, 0, 0, 0, 8'h00, 1);
      while (!s_axi.arready) tick();
      s_axi.araddr = 32'h00; s_axi.arvalid = 1'b1;
      tick();
      s_axi.arvalid = 1'b0;
      check("pending_rvalid", s_axi.rvalid, 1);
      rst = 1'b1;
      tick();
      check("midrst_bvalid", s_axi.bvalid, 0);
      check("midrst_rvalid", s_axi.rvalid, 0);
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      drive_done(1, 8'h99);
      rd(32'h00); rd(32'h04);

      // Randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         logic [31:0] a, d;
         logic [3:0]  s;
         a = 32'($urandom_range(0, 15)) << 2;
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 4))
            0: axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 8'h00, 0);
            1: axi_write(32'h00, d, 4'h9, 0, 0, 0, 0, 8'h00, 0);
            2: drive_done($urandom_range(0, 1), 8'($urandom));
            default: axi_read(a, $urandom_range(0, 2), 0, 0, 8'h00);
         endcase
      end
      rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C);
      tick();
      check("start_count_total", start_cnt, m_starts);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
